// File: rtl/pc_sequencer_if.sv
// Bundle of the control/status signals exchanged between the next-PC sequencer
// and the pipeline/PC register. clock and reset stay outside the bundle.
interface pc_sequencer_if;
  logic [31:0] pc_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        resume;
  logic        irq;
  logic        eret;
  logic        pc_write;
  logic [31:0] pc_data;
  logic        flush;
  logic        irq_ack;
  logic [31:0] epc;
  logic        in_isr;
  logic        halted;

  modport master (
    input  pc_in, stall, branch_taken, branch_target, jump, jump_target,
           halt, resume, irq, eret,
    output pc_write, pc_data, flush, irq_ack, epc, in_isr, halted
  );

  modport slave (
    output pc_in, stall, branch_taken, branch_target, jump, jump_target,
           halt, resume, irq, eret,
    input  pc_write, pc_data, flush, irq_ack, epc, in_isr, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller driving a PC register that loads data_in + 1, so every
// target is presented as target - 1. Interrupt support is built when PC_SEQ_IRQ_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0010,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  pc_sequencer_if.master  bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALTED} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        epc_q, epc_d;
  logic               in_isr_q, in_isr_d;

  logic               irq_take, eret_take;
  logic               redirect;
  logic               pc_write, flush, irq_ack;
  logic [31:0]        pc_data;

`ifdef PC_SEQ_IRQ_EN
  assign irq_take  = bus.irq  & ~in_isr_q;
  assign eret_take = bus.eret &  in_isr_q;
`else
  logic unused_irq;
  assign unused_irq = bus.irq ^ bus.eret;
  assign irq_take   = 1'b0;
  assign eret_take  = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    in_isr_d = in_isr_q;
    redirect = 1'b0;
    pc_write = 1'b0;
    pc_data  = 32'h0;
    flush    = 1'b0;
    irq_ack  = 1'b0;

    case (state_q)
      BOOT: begin
        pc_write = 1'b1;
        pc_data  = RESET_VECTOR - 32'd1;
        state_d  = RUN;
      end
      RUN: begin
        if (irq_take) begin
          pc_data  = IRQ_VECTOR - 32'd1;
          epc_d    = bus.pc_in + 32'd1;
          in_isr_d = 1'b1;
          irq_ack  = 1'b1;
          redirect = 1'b1;
        end else if (eret_take) begin
          pc_data  = epc_q - 32'd1;
          in_isr_d = 1'b0;
          redirect = 1'b1;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.jump) begin
          pc_data  = bus.jump_target - 32'd1;
          redirect = 1'b1;
        end else if (bus.branch_taken) begin
          pc_data  = bus.branch_target - 32'd1;
          redirect = 1'b1;
        end else if (!bus.stall) begin
          pc_write = 1'b1;
          pc_data  = bus.pc_in;
        end
      end
      REDIRECT: begin
        // Control inputs here come from squashed instructions and are ignored.
        flush = 1'b1;
        if (!bus.stall) begin
          pc_write = 1'b1;
          pc_data  = bus.pc_in;
        end
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      HALTED: begin
        if (irq_take) begin
          pc_data  = IRQ_VECTOR - 32'd1;
          epc_d    = bus.pc_in + 32'd1;
          in_isr_d = 1'b1;
          irq_ack  = 1'b1;
          redirect = 1'b1;
        end else if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (redirect) begin
      pc_write = 1'b1;
      flush    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = REDIRECT;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end

    // Outputs are quiet while reset is held, including the BOOT write.
    if (!reset) begin
      pc_write = 1'b0;
      pc_data  = 32'h0;
      flush    = 1'b0;
      irq_ack  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      cnt_q    <= '0;
      epc_q    <= 32'h0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
    end
  end

  assign bus.pc_write = pc_write;
  assign bus.pc_data  = pc_data;
  assign bus.flush    = flush;
  assign bus.irq_ack  = irq_ack;
  assign bus.epc      = epc_q;
  assign bus.in_isr   = in_isr_q;
  assign bus.halted   = reset & (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register (reset to
// all-ones, loads pc_data + 1 on pc_write) closing the loop through pc_in.
module tb_pc_sequencer;
  logic        clock;
  logic        reset;
  logic [31:0] pc_reg;
  int          n_pass;
  int          n_total;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            pc_reg <= 32'hFFFF_FFFF;
    else if (bus.pc_write) pc_reg <= bus.pc_data + 32'd1;
  end
  assign bus.pc_in = pc_reg;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_target = 0; bus.halt = 0; bus.resume = 0;
    bus.irq = 0; bus.eret = 0;
  endtask

  task automatic run_to(input logic [31:0] target);
    int n;
    n = 0;
    while (pc_reg !== target && n < 100) begin
      tick();
      n++;
    end
    n_total++;
    if (pc_reg !== target) $display("FAIL run_to: pc=%h required %h within 100 cycles", pc_reg, target);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.pc_write !== 1'b0) $display("FAIL reset_pc_write: got %b want 0", bus.pc_write); else n_pass++;
    n_total++; if (bus.pc_data !== 32'h0) $display("FAIL reset_pc_data: got %h want 0", bus.pc_data); else n_pass++;
    n_total++; if (bus.flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush); else n_pass++;
    n_total++; if (bus.halted !== 1'b0 || bus.in_isr !== 1'b0 || bus.epc !== 32'h0 || bus.irq_ack !== 1'b0)
      $display("FAIL reset_status: halted=%b in_isr=%b epc=%h irq_ack=%b want all 0", bus.halted, bus.in_isr, bus.epc, bus.irq_ack);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (bus.pc_write !== 1'b1 || bus.pc_data !== 32'hFFFF_FFFF)
      $display("FAIL boot_write: pc_write=%b pc_data=%h want 1 ffffffff", bus.pc_write, bus.pc_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (pc_reg !== 32'(i)) $display("FAIL boot_seq%0d: pc=%h want %h", i, pc_reg, 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    run_to(32'h5);
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    #1;
    n_total++; if (bus.pc_data !== 32'h3F || bus.pc_write !== 1'b1)
      $display("FAIL branch_data: pc_data=%h pc_write=%b want 3f 1", bus.pc_data, bus.pc_write);
    else n_pass++;
    n_total++; if (bus.flush !== 1'b1) $display("FAIL branch_flush0: got %b want 1", bus.flush); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== 32'h40) $display("FAIL branch_pc: got %h want 40", pc_reg); else n_pass++;
    bus.jump = 1; bus.jump_target = 32'h99;
    #1;
    n_total++; if (bus.flush !== 1'b1) $display("FAIL branch_flush1: got %b want 1", bus.flush); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== 32'h41) $display("FAIL branch_squash_jump: pc=%h want 41", pc_reg); else n_pass++;
    #1;
    n_total++; if (bus.flush !== 1'b0) $display("FAIL branch_flush_end: got %b want 0", bus.flush); else n_pass++;
  endtask

  task automatic test_stall();
    clear_inputs();
    bus.jump = 1; bus.jump_target = 32'h6;
    tick();
    clear_inputs();
    run_to(32'h8);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.pc_write !== 1'b0) $display("FAIL stall_write%0d: got %b want 0", i, bus.pc_write); else n_pass++;
      tick();
      n_total++; if (pc_reg !== 32'h8) $display("FAIL stall_hold%0d: pc=%h want 8", i, pc_reg); else n_pass++;
    end
    bus.jump = 1; bus.jump_target = 32'h80;
    #1;
    n_total++; if (bus.pc_data !== 32'h7F || bus.pc_write !== 1'b1)
      $display("FAIL stall_jump_data: pc_data=%h pc_write=%b want 7f 1", bus.pc_data, bus.pc_write);
    else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== 32'h80) $display("FAIL stall_jump_pc: got %h want 80", pc_reg); else n_pass++;
    tick();
  endtask

  task automatic test_halt();
    clear_inputs();
    bus.jump = 1; bus.jump_target = 32'h3;
    tick();
    clear_inputs();
    run_to(32'h4);
    bus.halt = 1;
    #1;
    n_total++; if (bus.pc_write !== 1'b0) $display("FAIL halt_write: got %b want 0", bus.pc_write); else n_pass++;
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (pc_reg !== 32'h4 || bus.halted !== 1'b1) $display("FAIL halt_hold%0d: pc=%h halted=%b want 4 1", i, pc_reg, bus.halted);
      else n_pass++;
      tick();
    end
    bus.resume = 1;
    #1;
    n_total++; if (bus.pc_write !== 1'b0) $display("FAIL resume_write: got %b want 0", bus.pc_write); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (bus.halted !== 1'b0 || pc_reg !== 32'h4)
      $display("FAIL resume_state: halted=%b pc=%h want 0 4", bus.halted, pc_reg);
    else n_pass++;
    tick();
    n_total++; if (pc_reg !== 32'h5) $display("FAIL resume_adv: pc=%h want 5", pc_reg); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] p;
`ifdef PC_SEQ_IRQ_EN
    clear_inputs();
    bus.jump = 1; bus.jump_target = 32'h1F;
    tick();
    clear_inputs();
    run_to(32'h20);
    bus.irq = 1;
    #1;
    n_total++; if (bus.irq_ack !== 1'b1 || bus.pc_data !== 32'hF)
      $display("FAIL irq_entry: irq_ack=%b pc_data=%h want 1 f", bus.irq_ack, bus.pc_data);
    else n_pass++;
    tick();
    n_total++; if (pc_reg !== 32'h10 || bus.epc !== 32'h21 || bus.in_isr !== 1'b1)
      $display("FAIL irq_state: pc=%h epc=%h in_isr=%b want 10 21 1", pc_reg, bus.epc, bus.in_isr);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++; if (bus.irq_ack !== 1'b0) $display("FAIL irq_retake%0d: irq_ack=%b want 0", i, bus.irq_ack); else n_pass++;
      tick();
    end
    n_total++; if (pc_reg !== 32'h12) $display("FAIL irq_isr_adv: pc=%h want 12", pc_reg); else n_pass++;
    bus.irq = 0; bus.eret = 1;
    #1;
    n_total++; if (bus.pc_data !== 32'h20) $display("FAIL eret_data: pc_data=%h want 20", bus.pc_data); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== 32'h21 || bus.in_isr !== 1'b0)
      $display("FAIL eret_state: pc=%h in_isr=%b want 21 0", pc_reg, bus.in_isr);
    else n_pass++;
    tick();
`else
    clear_inputs();
    tick();
    p = pc_reg;
    bus.irq = 1;
    #1;
    n_total++; if (bus.irq_ack !== 1'b0 || bus.pc_data !== p)
      $display("FAIL irq_off_ack: irq_ack=%b pc_data=%h want 0 %h", bus.irq_ack, bus.pc_data, p);
    else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== p + 32'd1 || bus.in_isr !== 1'b0 || bus.epc !== 32'h0)
      $display("FAIL irq_off_seq: pc=%h in_isr=%b epc=%h want %h 0 0", pc_reg, bus.in_isr, bus.epc, p + 32'd1);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    clear_inputs();
    tick();
    bus.jump = 1; bus.jump_target = 32'h0;
    #1;
    n_total++; if (bus.pc_data !== 32'hFFFF_FFFF) $display("FAIL wrap_data: pc_data=%h want ffffffff", bus.pc_data); else n_pass++;
    tick();
    clear_inputs();
    n_total++; if (pc_reg !== 32'h0) $display("FAIL wrap_pc: pc=%h want 0", pc_reg); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    clear_inputs();
    bus.jump = 1; bus.jump_target = 32'h50;
    tick();
    clear_inputs();
    #1;
    n_total++; if (bus.flush !== 1'b1) $display("FAIL midrst_flush_pre: got %b want 1", bus.flush); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (bus.flush !== 1'b0 || bus.pc_write !== 1'b0)
      $display("FAIL midrst_flush_drop: flush=%b pc_write=%b want 0 0", bus.flush, bus.pc_write);
    else n_pass++;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    n_total++; if (bus.pc_write !== 1'b1 || bus.pc_data !== 32'hFFFF_FFFF || bus.flush !== 1'b0)
      $display("FAIL midrst_boot: pc_write=%b pc_data=%h flush=%b want 1 ffffffff 0", bus.pc_write, bus.pc_data, bus.flush);
    else n_pass++;
    tick();
    n_total++; if (pc_reg !== 32'h0) $display("FAIL midrst_pc: pc=%h want 0", pc_reg); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_branch();
    test_stall();
    test_halt();
    test_irq();
    test_wrap();
    test_reset_mid_redirect();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
